// File: rtl/plastic_pkg.sv
// Shared types and arithmetic helpers for the plastic neuron.
// Holds the FSM state type, the default weight and the saturating weight adder.
package plastic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MAC,
      ST_OUT,
      ST_LEARN
   } state_e;

   localparam int W_INIT_DEFAULT = 999;

   // Narrowest accumulator that can hold N_SYN full-width products without overflow.
   function automatic int acc_w_min(input int in_w, input int w_w, input int n_syn);
      return in_w + w_w + $clog2(n_syn);
   endfunction

   function automatic logic signed [63:0] sat_add(input logic signed [63:0] w,
                                                  input logic signed [63:0] delta,
                                                  input int                 w_w);
      logic signed [63:0] sum;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sum = w + delta;
      hi  = (64'sd1 <<< (w_w - 1)) - 64'sd1;
      lo  = -(64'sd1 <<< (w_w - 1));
      if (sum > hi) begin
         return hi;
      end else if (sum < lo) begin
         return lo;
      end else begin
         return sum;
      end
   endfunction

endpackage

// File: rtl/plastic_syn_update.sv
// Combinational Hebbian update for one synapse: w + floor(x*err / 2^LR_SHIFT),
// saturated to the signed weight range.
module plastic_syn_update
   import plastic_pkg::*;
#(
   parameter int IN_W     = 16,
   parameter int W_W      = 16,
   parameter int LR_SHIFT = 4
) (
   input  logic signed [IN_W-1:0] x_i,
   input  logic signed [IN_W-1:0] err_i,
   input  logic signed [W_W-1:0]  w_i,
   output logic signed [W_W-1:0]  w_new_o
);

   logic signed [2*IN_W-1:0] prod;
   logic signed [2*IN_W-1:0] delta;

   assign prod  = x_i * err_i;
   // Arithmetic shift rounds toward minus infinity, so x=-1, err=1 still nudges w down.
   assign delta = prod >>> LR_SHIFT;

   assign w_new_o = W_W'(sat_add(64'(w_i), 64'(delta), W_W));

endmodule

// File: rtl/plastic_neuron_gen2.sv
// Plastic neuron: private weight bank, serial shared-multiplier MAC and an
// error-driven saturating Hebbian update, with valid/ready on both sides.
module plastic_neuron_gen2
   import plastic_pkg::*;
#(
   parameter int N_SYN    = 4,
   parameter int IN_W     = 16,
   parameter int W_W      = 16,
   parameter int ACC_W    = 40,
   parameter int LR_SHIFT = 4,
   parameter int W_INIT   = W_INIT_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [N_SYN*IN_W-1:0]        in_vec,
   input  logic signed [IN_W-1:0]       err,
   input  logic                         learn_en,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [ACC_W-1:0]      out_sum,
   input  logic                         wload_en,
   input  logic [$clog2(N_SYN)-1:0]     wload_idx,
   input  logic signed [W_W-1:0]        wload_data
);

   localparam int                IDX_W    = $clog2(N_SYN);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_SYN - 1);

   if (ACC_W < acc_w_min(IN_W, W_W, N_SYN)) begin : g_acc_w_too_narrow
      $error("plastic_neuron_gen2: ACC_W too narrow for N_SYN products");
   end

   state_e                   state_q;
   logic [IDX_W-1:0]         idx_q;
   logic [IDX_W-1:0]         idx_d;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  acc_d;
   logic signed [ACC_W-1:0]  out_sum_q;
   logic                     out_valid_q;
   logic signed [IN_W-1:0]   x_q [N_SYN];
   logic signed [IN_W-1:0]   err_q;
   logic                     learn_q;
   logic signed [W_W-1:0]    w_q [N_SYN];

   logic signed [IN_W-1:0]      x_sel;
   logic signed [W_W-1:0]       w_sel;
   logic signed [IN_W+W_W-1:0]  prod;
   logic signed [W_W-1:0]       w_new;

   // The single multiplier and the update unit both look at synapse idx_q.
   assign x_sel = x_q[idx_q];
   assign w_sel = w_q[idx_q];
   assign prod  = x_sel * w_sel;
   assign acc_d = acc_q + ACC_W'(prod);
   assign idx_d = idx_q + IDX_W'(1);

   plastic_syn_update #(
      .IN_W     (IN_W),
      .W_W      (W_W),
      .LR_SHIFT (LR_SHIFT)
   ) u_syn_update (
      .x_i     (x_sel),
      .err_i   (err_q),
      .w_i     (w_sel),
      .w_new_o (w_new)
   );

   assign in_ready  = rst_n && (state_q == ST_IDLE) && !wload_en;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;

   // NOTE: state is written with non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         acc_q       <= '0;
         out_sum_q   <= '0;
         out_valid_q <= 1'b0;
         err_q       <= '0;
         learn_q     <= 1'b0;
         // NOTE: the weight bank is reset on purpose; a reset mid-LEARN must
         // leave no partially updated weight behind.
         for (int i = 0; i < N_SYN; i++) begin
            w_q[i] <= W_W'(W_INIT);
            x_q[i] <= '0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (wload_en) begin
                  w_q[wload_idx] <= wload_data;
               end else if (in_valid) begin
                  for (int i = 0; i < N_SYN; i++) begin
                     x_q[i] <= in_vec[i*IN_W +: IN_W];
                  end
                  err_q   <= err;
                  learn_q <= learn_en;
                  acc_q   <= '0;
                  idx_q   <= '0;
                  state_q <= ST_MAC;
               end
            end
            ST_MAC: begin
               acc_q <= acc_d;
               idx_q <= idx_d;
               if (idx_q == LAST_IDX) begin
                  idx_q       <= '0;
                  out_sum_q   <= acc_d;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_OUT;
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  idx_q       <= '0;
                  state_q     <= learn_q ? ST_LEARN : ST_IDLE;
               end
            end
            ST_LEARN: begin
               w_q[idx_q] <= w_new;
               idx_q      <= idx_d;
               if (idx_q == LAST_IDX) begin
                  idx_q   <= '0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
